// File: rtl/recepcion.sv
// UART receiver (8N1, idle-high, LSB first) with oversampled bit centring,
// hold-until-ack byte buffer and sticky framing/overrun flags.
// Define RX_PARITY_EN for 8E1 frames with a sticky parity_err output.
module recepcion #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] dout,
  output logic       avail,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
`ifdef RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW      = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SC_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_END = SW'(OVERSAMPLE - 1);
  localparam logic [DW-1:0] DV_END = DW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        r_state, w_state_nx;
  logic          r_rx_s1, r_rx_s2;
  logic [DW-1:0] r_div;
  logic [SW-1:0] r_sc, w_sc_nx;
  logic [2:0]    r_bitpos, w_bitpos_nx;
  logic [7:0]    r_shreg, w_shreg_nx;
  logic          r_break;
  logic          w_rx, w_tick, w_centre, w_done, w_stop_bad;
`ifdef RX_PARITY_EN
  logic          w_par_bad;
`endif

  assign w_rx     = r_rx_s2;
  assign w_tick   = (r_div == DV_END);
  assign w_centre = w_tick && (r_sc == SC_END);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_div   <= '0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_sc_nx     = r_sc;
    w_bitpos_nx = r_bitpos;
    w_shreg_nx  = r_shreg;
    w_done      = 1'b0;
    w_stop_bad  = 1'b0;
`ifdef RX_PARITY_EN
    w_par_bad   = 1'b0;
`endif
    if (r_state != S_IDLE && w_tick)
      w_sc_nx = (r_sc == SC_END) ? '0 : r_sc + 1'b1;
    case (r_state)
      S_IDLE: begin
        // r_break keeps a held-low line after a framing error from retriggering
        if (!w_rx && !r_break) begin
          w_state_nx = S_START;
          w_sc_nx    = '0;
        end
      end
      S_START: begin
        if (w_tick && r_sc == SC_MID) begin
          if (w_rx) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx  = S_DATA;
            w_sc_nx     = '0;
            w_bitpos_nx = '0;
          end
        end
      end
      S_DATA: begin
        if (w_centre) begin
          w_shreg_nx[r_bitpos] = w_rx;
          if (r_bitpos == 3'd7) begin
`ifdef RX_PARITY_EN
            w_state_nx = S_PARITY;
`else
            w_state_nx = S_STOP;
`endif
          end else begin
            w_bitpos_nx = r_bitpos + 3'd1;
          end
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (w_centre) begin
          w_par_bad  = ^{r_shreg, w_rx};
          w_state_nx = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_centre) begin
          w_done     = 1'b1;
          w_stop_bad = !w_rx;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_sc      <= '0;
      r_bitpos  <= '0;
      r_shreg   <= '0;
      r_break   <= 1'b0;
      dout      <= '0;
      avail     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sc      <= w_sc_nx;
      r_bitpos  <= w_bitpos_nx;
      r_shreg   <= w_shreg_nx;
      r_break   <= w_stop_bad | (r_break & ~w_rx);
      if (w_done)
        dout <= r_shreg;
      avail     <= w_done | (avail & ~ack);
      frame_err <= w_stop_bad | (frame_err & ~err_clr);
      overrun   <= (w_done & avail & ~ack) | (overrun & ~err_clr);
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)
      parity_err <= 1'b0;
    else
      parity_err <= w_par_bad | (parity_err & ~err_clr);
  end
`endif

endmodule

// File: tb/tb_recepcion.sv
// Scoreboard bench for recepcion: expected bytes are queued as frames are
// driven and popped when the receiver finishes a frame (busy falling).
module tb_recepcion;
  localparam int unsigned CLK_FREQ   = 1600000;
  localparam int unsigned BAUD       = 10000;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned BIT_CLKS   = 160;
`ifdef RX_PARITY_EN
  localparam int LAT_LO = 1510 + 160;
  localparam int LAT_HI = 1530 + 160;
`else
  localparam int LAT_LO = 1510;
  localparam int LAT_HI = 1530;
`endif

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       avail, busy, frame_err, overrun;
`ifdef RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
`endif

  recepcion #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .rx       (rx),
    .ack      (ack),
    .dout     (dout),
    .avail    (avail),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .err_clr  (err_clr)
`ifdef RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int t0       = 0;
  int t_done   = 0;
  bit auto_ack = 1'b0;
  bit saw_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t0 = cyc;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk_in);
    end
`ifdef RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (BIT_CLKS) @(negedge clk_in);
`endif
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk_in);
  endtask

  task automatic pulse_ack();
    auto_ack = 1'b1;
    repeat (3) @(negedge clk_in);
    auto_ack = 1'b0;
  endtask

  // completion monitor: pops the scoreboard on each finished frame
  initial begin
    logic busy_d;
    exp_t e;
    busy_d = 1'b0;
    forever begin
      @(negedge clk_in);
      if (busy) saw_busy = 1'b1;
      if (busy_d && !busy && reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        t_done = cyc;
        check("sb_dout", 32'(dout), 32'(e.data));
        check("sb_avail", 32'(avail), 32'd1);
        check("sb_frame_err", 32'(frame_err), 32'(e.ferr));
      end
      busy_d = busy;
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      ack = auto_ack && avail && reset;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb;
    repeat (5) @(negedge clk_in);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_avail", 32'(avail), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk_in);

    // 1: single byte, latency and ack
    sb_q.push_back('{8'hA5, 1'b0});
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk_in);
    check("t1_avail", 32'(avail), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_latency", 32'(t_done - t0 >= LAT_LO && t_done - t0 <= LAT_HI), 32'd1);
    pulse_ack();
    check("t1_ack_clears", 32'(avail), 32'd0);

    // 2: back-to-back frames with acks
    auto_ack = 1'b1;
    sb_q.push_back('{8'h00, 1'b0});
    sb_q.push_back('{8'hFF, 1'b0});
    sb_q.push_back('{8'h3C, 1'b0});
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk_in);
    auto_ack = 1'b0;
    check("t2_overrun", 32'(overrun), 32'd0);
    check("t2_avail", 32'(avail), 32'd0);
    check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // 3: overrun without ack, then err_clr
    sb_q.push_back('{8'h11, 1'b0});
    send_frame(8'h11, 1'b1);
    sb_q.push_back('{8'h22, 1'b0});
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk_in);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_dout", 32'(dout), 32'h22);
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    @(negedge clk_in);
    check("t3_err_clr", 32'(overrun), 32'd0);
    check("t3_avail_kept", 32'(avail), 32'd1);
    pulse_ack();

    // 4: framing error, then line held low (break)
    sb_q.push_back('{8'h55, 1'b1});
    send_frame(8'h55, 1'b0);
    nb = 0;
    repeat (3 * BIT_CLKS) begin
      @(negedge clk_in);
      if (busy) nb++;
    end
    check("t4_no_restart", 32'(nb), 32'd0);
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_avail", 32'(avail), 32'd1);
    rx = 1'b1;
    repeat (20) @(negedge clk_in);
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    pulse_ack();
    check("t4_ferr_clr", 32'(frame_err), 32'd0);
    check("t4_avail_clr", 32'(avail), 32'd0);

    // 5: short glitch
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (40) @(negedge clk_in);
    rx = 1'b1;
    repeat (200) @(negedge clk_in);
    check("t5_busy_pulsed", 32'(saw_busy), 32'd1);
    check("t5_busy_idle", 32'(busy), 32'd0);
    check("t5_avail", 32'(avail), 32'd0);
    check("t5_frame_err", 32'(frame_err), 32'd0);

    // 6: reset mid-byte, then a clean frame
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk_in);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      repeat (BIT_CLKS) @(negedge clk_in);
    end
    check("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk_in);
    check("t6_rst_dout", 32'(dout), 32'h00);
    check("t6_rst_avail", 32'(avail), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_flags", 32'({frame_err, overrun}), 32'd0);
    repeat (3) @(negedge clk_in);
    rx = 1'b1;
    reset = 1'b1;
    repeat (200) @(negedge clk_in);
    check("t6_no_stray", 32'(avail), 32'd0);
    sb_q.push_back('{8'hC3, 1'b0});
    send_frame(8'hC3, 1'b1);
    repeat (4) @(negedge clk_in);
    check("t6_avail", 32'(avail), 32'd1);
`ifdef RX_PARITY_EN
    check("t6_parity_ok", 32'(parity_err), 32'd0);
    pulse_ack();
    par_flip = 1'b1;
    sb_q.push_back('{8'hC3, 1'b0});
    send_frame(8'hC3, 1'b1);
    par_flip = 1'b0;
    repeat (4) @(negedge clk_in);
    check("t6_parity_err", 32'(parity_err), 32'd1);
`endif
    pulse_ack();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/recepcion.md
Name: recepcion

Overview:
- UART receiver for the Bluetooth link: 8N1 serial frames arrive on `rx` and are delivered as bytes to the FPGA game logic.
- It is the receiving counterpart of the team's UART transmitter: idle-high line, LSB-first data.
- It oversamples the line from an internal baud-tick divider and holds each received byte until the consumer acknowledges it.
- It reports framing and overrun errors.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit period; must be an even number ≥ 4.

Ports:
- clk_in  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx  input  1  serial line, asynchronous to clk_in, idles high.
- ack  input  1  consumer pulse; clears `avail`.
- dout  output  8  last received byte.
- avail  output  1  `dout` holds an unread byte.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_err  output  1  sticky; set when the stop bit is sampled low.
- overrun  output  1  sticky; set when a byte completes while `avail` = 1.
- err_clr  input  1  synchronous pulse; clears `frame_err` and `overrun`.

Behaviour:
- Reset (reset = 0, async):
  - `dout` = 0x00; `avail`, `busy`, `frame_err`, `overrun` = 0.
  - State = IDLE; sync flops = 1; tick counter = 0; `bitpos` = 0.
- Input synchroniser:
  - `rx` passes through 2 flops before use; all references to "rx" below mean the synchronised value.
  - Latency is 2 clocks.
- Baud tick:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, minimum 1.
  - `tick` is a 1-clock pulse every DIV clocks.
  - The divider free-runs; it is never reset by frame activity.
- Sample counter `sc`:
  - Counts ticks 0..OVERSAMPLE-1 and wraps.
  - It is cleared when leaving IDLE.
- States:
  - IDLE:
    - On the first clock where rx = 0, go to START with `sc` = 0.
    - `busy` goes high the next clock.
  - START:
    - At `sc` = OVERSAMPLE/2-1 (mid start bit), re-sample rx.
    - If rx = 1, treat it as a glitch: return to IDLE, set no flag.
    - If rx = 0, clear `sc`, clear `bitpos`, and go to DATA.
  - DATA:
    - At `sc` = OVERSAMPLE-1 (each subsequent bit centre), shift rx into `shreg[bitpos]` (LSB first).
    - When `bitpos` = 7 is sampled, go to STOP; otherwise increment `bitpos`.
  - STOP:
    - At the next bit centre, sample the stop bit.
    - Load `dout` ← `shreg`; set `avail` = 1 regardless of the stop value.
    - If stop = 0, set `frame_err`.
    - If `avail` was already 1 (and not being acked in the same clock), set `overrun`; the new byte still overwrites `dout`.
    - Return to IDLE.
    - The falling-edge search resumes immediately, so back-to-back frames with one stop bit are received.
- Handshake:
  - `ack` = 1 clears `avail` on the next clock.
  - If `ack` and the byte-complete event coincide, `avail` stays 1, `dout` takes the new byte, and no overrun is flagged.
- `err_clr`:
  - Clears both sticky flags.
  - If it coincides with a new error event, the set wins.
- Line held low in IDLE after a framing error (break): no new frame starts until rx has returned to 1 for at least one clock.
- Reset mid-frame: immediate return to IDLE; the partial byte is discarded.
- Timing: a byte is available 9.5 bit periods plus 3 clocks after the start-bit falling edge reaches `rx` (±1 tick).

Optional Feature:
- Macro: RX_PARITY_EN.
- When defined:
  - Frame is 8E1: a PARITY state sits between DATA and STOP and samples one extra bit at its centre.
  - If XOR(data, parity bit) ≠ 0, set a sticky `parity_err` output (1 bit, reset 0, cleared by `err_clr`).
  - The byte is still delivered.
- When undefined:
  - No PARITY state and no `parity_err` port.
  - The frame is 8N1 exactly as above.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=10000, OVERSAMPLE=16, giving DIV=10 and 160 clocks/bit.
1. Send 0xA5 (8N1) → `avail` rises ~1520 clocks after the start edge; `dout` = 0xA5; `frame_err` = 0; `busy` low afterwards; `ack` clears `avail`.
2. Send 0x00, 0xFF, 0x3C back-to-back, acking each → three `avail` assertions with correct values; `overrun` = 0.
3. Send 0x11 then 0x22 without `ack` → `dout` = 0x22, `overrun` = 1; `err_clr` → `overrun` = 0.
4. Send 0x55 with the stop bit driven low → `dout` = 0x55, `avail` = 1, `frame_err` = 1; hold rx low for 3 bit times → no second frame starts.
5. Apply a 40-clock low glitch on rx → `busy` pulses, then returns to IDLE; `avail` stays 0.
6. Assert reset mid-byte (after 4 data bits) and resend 0xC3 → only 0xC3 is delivered; all outputs were 0 during reset. With RX_PARITY_EN: 0xC3 sent with wrong parity → `parity_err` = 1.
